sdram_resp_model: RTL

Target-side responder for the single-word SDRAM command interface issued by the FIFO's SDRAM controller. It decodes RAS_N/CAS_N/WE_N/CS_N commands, tracks the open row per bank, stores write data in a reduced-size array, and returns read data after CAS latency. It also flags protocol violations. It is used in place of the external SDRAM chip for simulation and on-chip loopback tests of the controller.

---
 rtl/sdram_resp_model_if.sv | 32 +++
 rtl/sdram_resp_model.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_resp_model_if.sv
// sdram_resp_model_if
//   Command/address side of the single-word SDRAM bus plus the responder's
//   status outputs. The bidirectional data bus is not carried here; it stays
//   a direct inout port of the responder so tristate resolution happens at a
//   plain module boundary.
//   master : the SDRAM controller (drives command/address/masks)
//   slave  : the responder model (drives status)
interface sdram_resp_model_if;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_we_n;
  logic        sdram_cas_n;
  logic        sdram_ras_n;
  logic        sdram_cs_n;
  logic        sdram_cke;
  logic [1:0]  sdram_dqm;
  logic        protocol_err;
  logic [2:0]  err_code;
  logic        rd_valid;

  modport master (
    output sdram_addr, sdram_ba, sdram_we_n, sdram_cas_n, sdram_ras_n,
           sdram_cs_n, sdram_cke, sdram_dqm,
    input  protocol_err, err_code, rd_valid
  );

  modport slave (
    input  sdram_addr, sdram_ba, sdram_we_n, sdram_cas_n, sdram_ras_n,
           sdram_cs_n, sdram_cke, sdram_dqm,
    output protocol_err, err_code, rd_valid
  );
endinterface

// File: rtl/sdram_resp_model.sv
// sdram_resp_model
//   Target-side SDRAM responder used in place of the external chip. Decodes
//   the RAS/CAS/WE/CS command each enabled clock, tracks the open row and
//   ACT->RD/WR spacing per bank, stores written words in a reduced array,
//   returns read data CL edges after the READ edge, and latches the first
//   protocol violation.
//   clk, rst_n : controller clock, async active-low reset
//   bus        : command/address/dqm in, protocol_err/err_code/rd_valid out
//   sdram_dq   : data bus, driven only while rd_valid is high

// One bank: open flag, open row and ACT->RD/WR spacing counter.
module sdram_resp_bank #(
  parameter int ROW_BITS = 4,
  parameter int TRCD     = 2,
  parameter int TW       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                act,
  input  logic                pre,
  input  logic [ROW_BITS-1:0] act_row,
  output logic                open,
  output logic [ROW_BITS-1:0] row,
  output logic                busy
);
  logic [TW-1:0] cnt;

  assign busy = (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open <= 1'b0;
      row  <= '0;
      cnt  <= '0;
    end else if (en) begin
      if (act) begin
        // ACT to an open bank simply replaces the row
        open <= 1'b1;
        row  <= act_row;
        cnt  <= TW'(TRCD - 1);
      end else begin
        if (pre) open <= 1'b0;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

module sdram_resp_model #(
  parameter int CL       = 2,
  parameter int TRCD     = 2,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_resp_model_if.slave   bus,
  inout  wire  [15:0]         sdram_dq
);
  localparam int TW    = (TRCD > 2) ? $clog2(TRCD) : 1;
  localparam int IW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [2:0] {
    C_MRS = 3'b000,
    C_REF = 3'b001,
    C_PRE = 3'b010,
    C_ACT = 3'b011,
    C_WR  = 3'b100,
    C_RD  = 3'b101,
    C_BST = 3'b110,
    C_NOP = 3'b111
  } cmd_e;

  typedef struct packed {
    cmd_e          cmd;
    logic [1:0]    ba;
    logic [12:0]   addr;
    logic [1:0]    dqm;
  } req_t;

  req_t req;
  logic en;

  assign en       = bus.sdram_cke;
  assign req.cmd  = bus.sdram_cs_n ? C_NOP
                  : cmd_e'({bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n});
  assign req.ba   = bus.sdram_ba;
  assign req.addr = bus.sdram_addr;
  assign req.dqm  = bus.sdram_dqm;

  // high address bits beyond the reduced row/column are intentionally ignored
  logic unused_addr;
  assign unused_addr = ^req.addr;

  // ---------------- per-bank state ----------------
  logic [3:0]               act_vec, pre_vec;
  logic [3:0]               bank_open, bank_busy;
  logic [3:0][ROW_BITS-1:0] bank_row;

  always_comb begin
    act_vec = '0;
    pre_vec = '0;
    for (int b = 0; b < 4; b++) begin
      act_vec[b] = (req.cmd == C_ACT) && (req.ba == 2'(b));
      pre_vec[b] = (req.cmd == C_PRE) && (req.addr[10] || (req.ba == 2'(b)));
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_resp_bank #(.ROW_BITS(ROW_BITS), .TRCD(TRCD), .TW(TW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .act     (act_vec[b]),
      .pre     (pre_vec[b]),
      .act_row (req.addr[ROW_BITS-1:0]),
      .open    (bank_open[b]),
      .row     (bank_row[b]),
      .busy    (bank_busy[b])
    );
  end

  logic                sel_open, sel_busy;
  logic [ROW_BITS-1:0] sel_row;
  logic [IW-1:0]       idx;
  logic                wr_do, rd_do;

  assign sel_open = bank_open[req.ba];
  assign sel_busy = bank_busy[req.ba];
  assign sel_row  = bank_row[req.ba];
  assign idx      = {req.ba, sel_row, req.addr[COL_BITS-1:0]};
  // closed-bank accesses are dropped; early (trcd) accesses still happen
  assign wr_do    = en && (req.cmd == C_WR) && sel_open;
  assign rd_do    = en && (req.cmd == C_RD) && sel_open;

  // ---------------- storage (never reset) ----------------
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_do) begin
      if (!req.dqm[0]) mem[idx][7:0]  <= sdram_dq[7:0];
      if (!req.dqm[1]) mem[idx][15:8] <= sdram_dq[15:8];
    end
    // read mask is applied at capture: masked byte comes back as zero
    if (rd_do)
      rd_q <= {req.dqm[1] ? 8'h00 : mem[idx][15:8],
               req.dqm[0] ? 8'h00 : mem[idx][7:0]};
  end

  // ---------------- read pipeline ----------------
  // stage 0 is loaded on the READ edge; stage CL is the bus-driving cycle.
  // cke low freezes every stage, stretching the latency by one cycle.
  logic [CL:0]       vld_pipe;
  logic [CL:1][15:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[CL-1:0], rd_do};
  end

  always_ff @(posedge clk) begin
    if (en) dat_pipe <= {dat_pipe[CL-1:1], rd_q};
  end

  assign bus.rd_valid = vld_pipe[CL];
  assign sdram_dq     = vld_pipe[CL] ? dat_pipe[CL] : 16'hzzzz;

  // ---------------- violation capture ----------------
  logic [2:0] err_now;

  always_comb begin
    err_now = 3'd0;
    if (en) begin
      case (req.cmd)
        C_RD, C_WR: begin
          if (!sel_open)                              err_now = 3'd1;
          else if (sel_busy)                          err_now = 3'd2;
          else if (req.cmd == C_WR && vld_pipe[CL])   err_now = 3'd5;
        end
        C_ACT:   if (sel_open)    err_now = 3'd3;
        C_REF:   if (|bank_open)  err_now = 3'd4;
        default: err_now = 3'd0;
      endcase
    end
  end

  logic       err_q;
  logic [2:0] code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      code_q <= 3'd0;
    end else if (!err_q && err_now != 3'd0) begin
      err_q  <= 1'b1;
      code_q <= err_now;
    end
  end

  assign bus.protocol_err = err_q;
  assign bus.err_code     = code_q;
endmodule
